mem_port_arbiter: RTL and testbench

- Shares the single core memory port between the load/store path (m0, issued from EX) and instruction fetch (m1, read-only).
- Sits between the fetch/EX stages and the memory bus.
- Fixed priority to load/store, with a starvation guard that forces a fetch grant.
- One outstanding transaction at a time; generates a fetch hold, and discards fetch responses invalidated by a jump flush.

---
 rtl/mem_port_arb_pkg.sv | 20 ++
 rtl/mem_port_arb_prio.sv | 39 +++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared types for the core memory-port arbiter: FSM states, port ownership
// and the data word returned on a watchdog abort.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_LSU = 1'b0,
        OWN_IF  = 1'b1
    } owner_t;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_port_arb_prio.sv
// Winner select between load/store (m0) and fetch (m1), with a saturating
// count of consecutive m0 wins that forces a fetch grant once it hits the limit.
module mem_port_arb_prio
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic m0_req,
    input  logic m1_req,
    output logic m0_win_c,
    output logic m1_win_c
);

    logic [CNT_W-1:0] cnt;

    always_comb begin
        m0_win_c = arb_en & m0_req & (~m1_req | (cnt < CNT_W'(STARVE_MAX)));
        m1_win_c = arb_en & m1_req & ~m0_win_c;
    end

    // Only grants move the counter; idle cycles leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (m0_win_c) begin
            if (!m1_req) begin
                cnt <= '0;
            end else if (cnt < CNT_W'(STARVE_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (m1_win_c) begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single core memory port between load/store (m0) and fetch (m1).
// Optional watchdog abort is enabled by defining MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned STARVE_MAX     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_req_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    input  logic                flush_i,
    output logic                hold_if_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_be_o,
    input  logic                s_gnt_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    output logic                err_o
);

    localparam int unsigned BE_W = DATA_W / 8;

    state_t            state;
    state_t            state_next;
    owner_t            owner;
    logic              drop_q;
    logic              arb_en_c;
    logic              m0_win_c;
    logic              m1_win_c;
    logic              resp_c;
    logic              timeout_c;
    logic [DATA_W-1:0] resp_data_c;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;

    assign arb_en_c = ~rst_i & (state == IDLE);

    mem_port_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk      (clk_i),
        .rst      (rst_i),
        .arb_en   (arb_en_c),
        .m0_req   (m0_req_i),
        .m1_req   (m1_req_i),
        .m0_win_c (m0_win_c),
        .m1_win_c (m1_win_c)
    );

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] wdog;

    // Cycles spent in REQ+WAIT; the abort fires on the TIMEOUT_CYCLES-th one.
    always_ff @(posedge clk_i) begin
        if (rst_i || state == IDLE) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + WDOG_W'(1);
        end
    end

    assign timeout_c = (state != IDLE) && (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;

    assign unused_cfg = ^32'(TIMEOUT_CYCLES);
    assign timeout_c  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        resp_c      = 1'b0;
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        hold_if_o   = 1'b0;
        err_o       = 1'b0;
        s_req_o     = 1'b0;
        resp_data_c = s_rdata_i;

        case (state)
            IDLE: if (m0_win_c || m1_win_c) state_next = REQ;
            REQ:  if (s_gnt_i) state_next = WAIT;
            WAIT: begin
                if (s_rvalid_i) begin
                    state_next = IDLE;
                    resp_c     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (timeout_c) begin
            state_next  = IDLE;
            resp_c      = 1'b1;
            resp_data_c = DATA_W'(ERR_RDATA);
        end

        m0_gnt_o    = m0_win_c;
        m1_gnt_o    = m1_win_c;
        hold_if_o   = ~rst_i & m1_req_i & ~m1_win_c;
        s_req_o     = (state == REQ);
        err_o       = ~rst_i & timeout_c;
        m0_rvalid_o = ~rst_i & resp_c & (owner == OWN_LSU);
        // A flush arriving with the response itself must also kill it.
        m1_rvalid_o = ~rst_i & resp_c & (owner == OWN_IF) & ~drop_q & ~flush_i;
    end

    assign m0_rdata_o = m0_rvalid_o ? resp_data_c : m0_rdata_q;
    assign m1_rdata_o = m1_rvalid_o ? resp_data_c : m1_rdata_q;

    // Latch the winner's payload; fetches are always full-word reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner     <= OWN_LSU;
            s_we_o    <= 1'b0;
            s_addr_o  <= '0;
            s_wdata_o <= '0;
            s_be_o    <= '0;
        end else if (m0_win_c) begin
            owner     <= OWN_LSU;
            s_we_o    <= m0_we_i;
            s_addr_o  <= m0_addr_i;
            s_wdata_o <= m0_wdata_i;
            s_be_o    <= m0_be_i;
        end else if (m1_win_c) begin
            owner     <= OWN_IF;
            s_we_o    <= 1'b0;
            s_addr_o  <= m1_addr_i;
            s_wdata_o <= '0;
            s_be_o    <= {BE_W{1'b1}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q <= 1'b0;
        end else if (state_next == IDLE) begin
            drop_q <= 1'b0;
        end else if (flush_i && owner == OWN_IF && state != IDLE) begin
            drop_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            if (m0_rvalid_o) m0_rdata_q <= resp_data_c;
            if (m1_rvalid_o) m1_rdata_q <= resp_data_c;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs change on the falling edge and
// outputs are sampled 1ns later, before the next rising edge.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_req_i = 1'b0;
    logic        m0_we_i = 1'b0;
    logic [31:0] m0_addr_i = '0;
    logic [31:0] m0_wdata_i = '0;
    logic [3:0]  m0_be_i = '0;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;
    logic [31:0] m0_rdata_o;
    logic        m1_req_i = 1'b0;
    logic [31:0] m1_addr_i = '0;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;
    logic [31:0] m1_rdata_o;
    logic        flush_i = 1'b0;
    logic        hold_if_o;
    logic        s_req_o;
    logic        s_we_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic [3:0]  s_be_o;
    logic        s_gnt_i = 1'b0;
    logic        s_rvalid_i = 1'b0;
    logic [31:0] s_rdata_i = '0;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .STARVE_MAX     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .m0_req_i    (m0_req_i),
        .m0_we_i     (m0_we_i),
        .m0_addr_i   (m0_addr_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_be_i     (m0_be_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (m1_req_i),
        .m1_addr_i   (m1_addr_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
        .flush_i     (flush_i),
        .hold_if_o   (hold_if_o),
        .s_req_o     (s_req_o),
        .s_we_o      (s_we_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_be_o      (s_be_o),
        .s_gnt_i     (s_gnt_i),
        .s_rvalid_i  (s_rvalid_i),
        .s_rdata_i   (s_rdata_i),
        .err_o       (err_o)
    );

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        tick();
        #1;
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, hold_if_o, s_req_o, s_we_o, err_o} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, hold_if_o, s_req_o, s_we_o, err_o});
        end
        n_checks++;
        if ({s_addr_o, s_wdata_o, s_be_o, m0_rdata_o, m1_rdata_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h %h expected all zero",
                     s_addr_o, s_wdata_o, s_be_o, m0_rdata_o, m1_rdata_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_lone_fetch();
        m1_req_i = 1'b1; m1_addr_i = 32'h100;
        #1;
        n_checks++;
        if ({m1_gnt_o, m0_gnt_o, hold_if_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL fetch_gnt: got gnt1/gnt0/hold=%b expected 100", {m1_gnt_o, m0_gnt_o, hold_if_o});
        end
        tick();
        m1_req_i = 1'b0; s_gnt_i = 1'b1;
        #1;
        n_checks++;
        if ({s_req_o, s_we_o, s_addr_o, s_be_o} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
            n_fail++;
            $display("FAIL fetch_bus: got req=%b we=%b addr=%h be=%h expected 1 0 00000100 f",
                     s_req_o, s_we_o, s_addr_o, s_be_o);
        end
        tick();
        s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h13;
        #1;
        n_checks++;
        if ({m1_rvalid_o, m0_rvalid_o, s_req_o, m1_rdata_o} !== {3'b100, 32'h13}) begin
            n_fail++;
            $display("FAIL fetch_resp: got rv1=%b rv0=%b sreq=%b rdata=%h expected 1 0 0 00000013",
                     m1_rvalid_o, m0_rvalid_o, s_req_o, m1_rdata_o);
        end
        tick();
        s_rvalid_i = 1'b0; s_rdata_i = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if ({m1_rvalid_o, err_o, m1_rdata_o} !== {2'b00, 32'h13}) begin
            n_fail++;
            $display("FAIL fetch_hold: got rv1=%b err=%b rdata=%h expected 0 0 00000013",
                     m1_rvalid_o, err_o, m1_rdata_o);
        end
    endtask

    task automatic test_starvation();
        logic exp_m1;
        m0_req_i = 1'b1; m0_addr_i = 32'h3000; m0_we_i = 1'b0; m0_be_i = 4'hF;
        m1_req_i = 1'b1; m1_addr_i = 32'h400;
        for (int k = 0; k < 6; k++) begin
            exp_m1 = (k == 4);
            #1;
            n_checks++;
            if ({m0_gnt_o, m1_gnt_o, hold_if_o} !== {~exp_m1, exp_m1, ~exp_m1}) begin
                n_fail++;
                $display("FAIL starve_gnt[%0d]: got gnt0/gnt1/hold=%b expected %b",
                         k, {m0_gnt_o, m1_gnt_o, hold_if_o}, {~exp_m1, exp_m1, ~exp_m1});
            end
            tick();
            s_gnt_i = 1'b1;
            tick();
            s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h1000 + k;
            #1;
            n_checks++;
            if ({m0_rvalid_o, m1_rvalid_o} !== {~exp_m1, exp_m1}) begin
                n_fail++;
                $display("FAIL starve_rv[%0d]: got rv0/rv1=%b expected %b",
                         k, {m0_rvalid_o, m1_rvalid_o}, {~exp_m1, exp_m1});
            end
            tick();
            s_rvalid_i = 1'b0;
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        n_checks++;
        if (m1_rdata_o !== 32'h1004) begin
            n_fail++;
            $display("FAIL starve_rdata1: got %h expected 00001004", m1_rdata_o);
        end
    endtask

    task automatic test_write();
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h2000;
        m0_wdata_i = 32'hA5A5_A5A5; m0_be_i = 4'b0011;
        #1;
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL write_gnt: got gnt0/gnt1=%b expected 10", {m0_gnt_o, m1_gnt_o});
        end
        tick();
        m0_req_i = 1'b0; m0_we_i = 1'b0; s_gnt_i = 1'b1;
        #1;
        n_checks++;
        if ({s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o} !== {2'b11, 32'h2000, 32'hA5A5_A5A5, 4'b0011}) begin
            n_fail++;
            $display("FAIL write_bus: got req=%b we=%b addr=%h wdata=%h be=%b expected 1 1 00002000 a5a5a5a5 0011",
                     s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o);
        end
        tick();
        s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h0;
        #1;
        n_checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL write_ack: got rv0/rv1=%b expected 10", {m0_rvalid_o, m1_rvalid_o});
        end
        tick();
        s_rvalid_i = 1'b0;
    endtask

    task automatic test_flush();
        // Flush while waiting, response arrives a cycle later
        m1_req_i = 1'b1; m1_addr_i = 32'h200;
        tick();
        m1_req_i = 1'b0; s_gnt_i = 1'b1;
        tick();
        s_gnt_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h55;
        #1;
        n_checks++;
        if ({m1_rvalid_o, m1_rdata_o} !== {1'b0, 32'h1004}) begin
            n_fail++;
            $display("FAIL flush_drop: got rv1=%b rdata=%h expected 0 00001004", m1_rvalid_o, m1_rdata_o);
        end
        tick();
        s_rvalid_i = 1'b0; m0_req_i = 1'b1; m0_addr_i = 32'h44;
        #1;
        n_checks++;
        if (m0_gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_next_gnt: got %b expected 1", m0_gnt_o);
        end
        tick();
        // Flush with owner m0, coincident with the response: no effect
        m0_req_i = 1'b0; s_gnt_i = 1'b1;
        tick();
        s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h66; flush_i = 1'b1;
        #1;
        n_checks++;
        if ({m0_rvalid_o, m0_rdata_o} !== {1'b1, 32'h66}) begin
            n_fail++;
            $display("FAIL flush_m0: got rv0=%b rdata=%h expected 1 00000066", m0_rvalid_o, m0_rdata_o);
        end
        tick();
        s_rvalid_i = 1'b0; flush_i = 1'b0;
        // Fetch flushed in the same cycle as its response
        m1_req_i = 1'b1; m1_addr_i = 32'h300;
        tick();
        m1_req_i = 1'b0; s_gnt_i = 1'b1;
        tick();
        s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h77; flush_i = 1'b1;
        #1;
        n_checks++;
        if (m1_rvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_same_cycle: got rv1=%b expected 0", m1_rvalid_o);
        end
        tick();
        s_rvalid_i = 1'b0; flush_i = 1'b0;
        // Drop flag must not leak into the next fetch
        m1_req_i = 1'b1; m1_addr_i = 32'h304;
        tick();
        m1_req_i = 1'b0; s_gnt_i = 1'b1;
        tick();
        s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h88;
        #1;
        n_checks++;
        if ({m1_rvalid_o, m1_rdata_o} !== {1'b1, 32'h88}) begin
            n_fail++;
            $display("FAIL flush_cleared: got rv1=%b rdata=%h expected 1 00000088", m1_rvalid_o, m1_rdata_o);
        end
        tick();
        s_rvalid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h500; m0_wdata_i = 32'h1234_5678; m0_be_i = 4'hF;
        tick();
        m0_req_i = 1'b0; m0_we_i = 1'b0; s_gnt_i = 1'b1;
        tick();
        s_gnt_i = 1'b0; rst_i = 1'b1;
        tick();
        rst_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h99;
        #1;
        n_checks++;
        if ({m0_rvalid_o, m1_rvalid_o, s_req_o, s_we_o, err_o, hold_if_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: got rv0/rv1/sreq/we/err/hold=%b expected 000000",
                     {m0_rvalid_o, m1_rvalid_o, s_req_o, s_we_o, err_o, hold_if_o});
        end
        n_checks++;
        if ({s_addr_o, s_wdata_o, s_be_o, m0_rdata_o, m1_rdata_o} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_data: got %h %h %h %h %h expected all zero",
                     s_addr_o, s_wdata_o, s_be_o, m0_rdata_o, m1_rdata_o);
        end
        tick();
        s_rvalid_i = 1'b0;
        #1;
        n_checks++;
        if ({m0_rvalid_o, m1_rvalid_o, s_req_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_idle: got rv0/rv1/sreq=%b expected 000", {m0_rvalid_o, m1_rvalid_o, s_req_o});
        end
    endtask

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        m0_req_i = 1'b1; m0_addr_i = 32'h600;
        tick();
        m0_req_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            n_checks++;
            if ({err_o, m0_rvalid_o} !== {2{c == 8}}) begin
                n_fail++;
                $display("FAIL timeout_cycle[%0d]: got err/rv0=%b expected %b",
                         c, {err_o, m0_rvalid_o}, {2{c == 8}});
            end
            if (c == 8) begin
                n_checks++;
                if (m0_rdata_o !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL timeout_rdata: got %h expected deadbeef", m0_rdata_o);
                end
            end
            tick();
        end
        m0_req_i = 1'b1;
        #1;
        n_checks++;
        if ({m0_gnt_o, err_o, s_req_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL timeout_idle: got gnt0/err/sreq=%b expected 100", {m0_gnt_o, err_o, s_req_o});
        end
        tick();
        m0_req_i = 1'b0; s_gnt_i = 1'b1;
        tick();
        s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
        tick();
        s_rvalid_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_lone_fetch();
        test_starvation();
        test_write();
        test_flush();
        test_reset_mid();
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
